polirv_mem: RTL and testbench
=============================

# polirv_mem

Memory responder for the polirv core: the target end of the core's instruction-fetch and data-memory interfaces. It holds the instruction ROM and the data RAM, drives the shared 64-bit bidirectional data bus on reads, and captures stores on writes. A boot-loader FSM fills both memories from a streaming valid/ready port while holding the core in reset, then releases the core.

## Interface
- i_addr_bits, 6: width of i_mem_addr (byte address); instruction depth = 2^(i_addr_bits-2) words of 32 bits
- d_addr_bits, 6: width of d_mem_addr (byte address); data depth = 2^(d_addr_bits-3) doublewords of 64 bits
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- i_mem_addr  input  i_addr_bits  fetch byte address from core
- i_mem_data  output  32  fetched instruction
- d_mem_we  input  1  store enable from core
- d_mem_addr  input  d_addr_bits  data byte address from core
- d_mem_data  inout  64  shared data bus; driven here on reads only
- ld_valid  input  1  loader word valid
- ld_ready  output  1  loader word accepted when ld_valid&ld_ready
- ld_data  input  64  loader word; instruction phase uses [31:0]
- ld_last  input  1  marks last word of the current phase
- core_rst_n  output  1  active-low reset to core; 0 until loading finishes

## Operation
- Indexing: instruction index = i_mem_addr[i_addr_bits-1:2]; data index = d_mem_addr[d_addr_bits-1:3]; low address bits ignored (no misalignment fault).
- FSM states: LOAD_I, LOAD_D, RUN. Reset state LOAD_I, load counter cnt = 0.
- LOAD_I: ld_ready = 1. On handshake, imem[cnt] <= ld_data[31:0], cnt++. If ld_last set or cnt = 2^(i_addr_bits-2)-1 on that handshake -> LOAD_D, cnt <= 0.
- LOAD_D: ld_ready = 1. On handshake, dmem[cnt] <= ld_data, cnt++. If ld_last set or cnt = 2^(d_addr_bits-3)-1 -> RUN.
- RUN: ld_ready = 0; ld_valid ignored. Core port active.
- Reads (RUN): i_mem_data = imem[index] combinationally; d_mem_data driven with dmem[index] combinationally when d_mem_we = 0.
- Writes (RUN): d_mem_we = 1 -> bus released (high-Z); dmem[index] <= d_mem_data at rising clk.
- Outside RUN: d_mem_data high-Z; i_mem_data = 32'h0000_0013 (NOP); d_mem_we ignored.
- Memory arrays have no reset; contents persist across rst_n.

## Timing
- Reset values: ld_ready = 0 while rst_n = 0, then 1 combinationally in LOAD_I; core_rst_n = 0; d_mem_data high-Z; i_mem_data = NOP; state LOAD_I; cnt = 0.
- core_rst_n is registered: set to 1 at the edge where the state enters RUN; 0 asynchronously on rst_n low.
- Read latency 0 cycles (combinational, single-cycle core); write takes effect at next rising edge, readable in the following cycle.
- Bus turnaround: drive enable = (state = RUN) & ~d_mem_we, purely combinational; no extra cycle.
- Loader throughput: one word per cycle when ld_valid held high.
- Phase with ld_last on first word: one word written, phase ends; remaining words keep prior contents.
- Counter never wraps: max-depth word terminates the phase regardless of ld_last.
- rst_n low mid-load or mid-RUN: immediate return to LOAD_I, core_rst_n = 0, bus released, in-flight store discarded if the edge coincides with reset.

## Test plan
- Reset, then stream 3 instr words 0x00500093, 0x00A00113, 0x002081B3 (last on 3rd) and 2 data words 0x1111, 0x2222 (last) -> ld_ready falls and core_rst_n rises the cycle after the 5th handshake; i_mem_addr = 8 -> i_mem_data = 0x002081B3.
- RUN, d_mem_we = 0, d_mem_addr = 8 -> d_mem_data = 0x2222; d_mem_addr = 13 -> still 0x2222 (low bits ignored).
- RUN, d_mem_we = 1, bench drives 0xDEADBEEF_CAFEF00D at addr 16 -> bus not driven by block that cycle; next cycle read addr 16 returns 0xDEADBEEF_CAFEF00D.
- Loader with ld_valid toggling every other cycle, 16 instr words without ld_last -> phase ends at word 16, imem[15] correct, LOAD_D entered.
- ld_valid high during RUN with ld_data = 0xFFFF -> no memory change, ld_ready = 0.
- rst_n pulsed low during LOAD_D after 2 words -> core_rst_n = 0, ld_ready = 1 in LOAD_I, previously loaded imem contents unchanged after reload of word 0 only.

Source files
------------

// File: rtl/polirv_mem.sv
// polirv_mem: memory responder for the polirv core.
//
// Holds the instruction ROM (32-bit words) and the data RAM (64-bit doublewords).
// After reset, a loader FSM fills both memories from a valid/ready stream and
// keeps the core in reset. It then releases the core and serves its fetch and
// data ports.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   i_mem_addr     fetch byte address; i_mem_data returns the word combinationally
//   d_mem_we       store enable from the core
//   d_mem_addr     data byte address
//   d_mem_data     shared bidirectional bus; driven here only on RUN-state reads
//   ld_valid/ld_ready/ld_data/ld_last   loader stream (instruction phase uses [31:0])
//   core_rst_n     registered active-low reset to the core; rises on entry to RUN
module polirv_mem #(
  parameter int unsigned i_addr_bits = 6,
  parameter int unsigned d_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [i_addr_bits-1:0] i_mem_addr,
  output logic [31:0]            i_mem_data,
  input  logic                   d_mem_we,
  input  logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [63:0]            d_mem_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [63:0]            ld_data,
  input  logic                   ld_last,
  output logic                   core_rst_n
);

  localparam int unsigned I_IDX_W = i_addr_bits - 2;
  localparam int unsigned D_IDX_W = d_addr_bits - 3;
  localparam int unsigned I_DEPTH = 1 << I_IDX_W;
  localparam int unsigned D_DEPTH = 1 << D_IDX_W;
  localparam int unsigned CNT_W   = (I_IDX_W > D_IDX_W) ? I_IDX_W : D_IDX_W;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {LOAD_I, LOAD_D, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_rst_n_q, core_rst_n_d;

  logic [31:0] imem [I_DEPTH];
  logic [63:0] dmem [D_DEPTH];

  logic [I_IDX_W-1:0] i_idx;
  logic [D_IDX_W-1:0] d_idx;
  logic               handshake;
  logic               imem_ld_we;
  logic               dmem_ld_we;
  logic               core_we;
  logic               bus_oe;
  logic               unused_addr_bits;

  // Sub-word address bits carry no meaning here: accesses are word/doubleword
  // aligned by truncation, with no misalignment fault.
  assign i_idx            = i_mem_addr[i_addr_bits-1:2];
  assign d_idx            = d_mem_addr[d_addr_bits-1:3];
  assign unused_addr_bits = ^{i_mem_addr[1:0], d_mem_addr[2:0]};

  // ld_ready is gated by rst_n so that no handshake is seen while reset is held.
  assign ld_ready   = rst_n & (state_q != RUN);
  assign handshake  = ld_valid & ld_ready;
  assign imem_ld_we = handshake & (state_q == LOAD_I);
  assign dmem_ld_we = handshake & (state_q == LOAD_D);
  assign core_we    = (state_q == RUN) & d_mem_we;

  // Bus turnaround is purely combinational: the core's write enable releases
  // the bus in the same cycle.
  assign bus_oe     = (state_q == RUN) & ~d_mem_we;
  assign d_mem_data = bus_oe ? dmem[d_idx] : 64'bz;
  assign i_mem_data = (state_q == RUN) ? imem[i_idx] : NOP;
  assign core_rst_n = core_rst_n_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_rst_n_d = core_rst_n_q;
    unique case (state_q)
      LOAD_I: begin
        if (handshake) begin
          cnt_d = cnt_q + CNT_W'(1);
          // The last slot ends the phase even without ld_last, so cnt never wraps.
          if (ld_last || cnt_q == CNT_W'(I_DEPTH - 1)) begin
            state_d = LOAD_D;
            cnt_d   = '0;
          end
        end
      end
      LOAD_D: begin
        if (handshake) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (ld_last || cnt_q == CNT_W'(D_DEPTH - 1)) begin
            state_d      = RUN;
            cnt_d        = '0;
            core_rst_n_d = 1'b1;
          end
        end
      end
      RUN:     ;
      default: state_d = LOAD_I;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD_I;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  // NOTE: the memory arrays are deliberately not reset. Contents persist across
  // rst_n, and a reset would turn the arrays into flop banks.
  // A store that coincides with reset is dropped, because reset forces
  // state_q out of RUN asynchronously.
  always_ff @(posedge clk) begin
    if (imem_ld_we) begin
      imem[cnt_q[I_IDX_W-1:0]] <= ld_data[31:0];
    end
    if (dmem_ld_we) begin
      dmem[cnt_q[D_IDX_W-1:0]] <= ld_data;
    end else if (core_we) begin
      dmem[d_idx] <= d_mem_data;
    end
  end

endmodule

// File: tb/tb_polirv_mem.sv
// Self-checking bench for polirv_mem: loader streaming, RUN-state reads and
// writes, bus release on stores, loader ignored in RUN, max-depth phase end,
// and reset in the middle of a load with memory contents persisting.
module tb_polirv_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  i_mem_addr;
  logic [31:0] i_mem_data;
  logic        d_mem_we;
  logic [5:0]  d_mem_addr;
  wire  [63:0] d_mem_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [63:0] ld_data;
  logic        ld_last;
  logic        core_rst_n;

  logic        tb_oe;
  logic [63:0] tb_wdata;

  assign d_mem_data = tb_oe ? tb_wdata : 64'bz;

  always #5 clk = ~clk;

  polirv_mem #(.i_addr_bits(6), .d_addr_bits(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mem_addr (i_mem_addr),
    .i_mem_data (i_mem_data),
    .d_mem_we   (d_mem_we),
    .d_mem_addr (d_mem_addr),
    .d_mem_data (d_mem_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .core_rst_n (core_rst_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb_q [$];

  typedef struct packed {
    logic        we;
    logic [5:0]  d_addr;
    logic [63:0] wdata;
    logic [63:0] d_exp;
    logic [5:0]  i_addr;
    logic [31:0] i_exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  // Presents one loader word after 'gap' idle cycles and returns just after the
  // edge that accepted it.
  task automatic ld_word(input logic [63:0] data, input logic last, input int gap);
    bit got;
    got = 1'b0;
    ld_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ld_ready) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ld_handshake_timeout: got ld_ready=0 for 20 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    d_mem_we = 1'b0;
    tb_oe    = 1'b0;
    #1;
    check("rst_ld_ready", ld_ready, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_i_mem_nop", i_mem_data, 32'h0000_0013);
    check("rst_bus_released", dut.bus_oe, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("load_i_ld_ready", ld_ready, 1);
    check("load_i_core_rst_n", core_rst_n, 0);
  endtask

  task automatic run_read(input string name, input logic [5:0] ia, input logic [31:0] ie,
                          input logic [5:0] da, input logic [63:0] de);
    @(posedge clk);
    #1;
    d_mem_we   = 1'b0;
    tb_oe      = 1'b0;
    i_mem_addr = ia;
    d_mem_addr = da;
    sb_q.push_back(de);
    @(negedge clk);
    check({name, "_i"}, i_mem_data, ie);
    check({name, "_d"}, d_mem_data, sb_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    i_mem_addr = '0;
    d_mem_addr = '0;
    d_mem_we   = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    tb_oe      = 1'b0;
    tb_wdata   = '0;

    // ---- Basic load: 3 instruction words, 2 data words ----
    do_reset();
    i_mem_addr = 6'd8;
    ld_word(64'h0000_0000_0050_0093, 1'b0, 0);
    ld_word(64'h0000_0000_00A0_0113, 1'b0, 0);
    ld_word(64'h0000_0000_0020_81B3, 1'b1, 0);
    check("load_d_i_mem_nop", i_mem_data, 32'h0000_0013);
    check("load_d_bus_released", dut.bus_oe, 0);
    ld_word(64'h1111, 1'b0, 0);
    check("pre_run_core_rst_n", core_rst_n, 0);
    check("pre_run_ld_ready", ld_ready, 1);
    ld_word(64'h2222, 1'b1, 0);
    check("run_core_rst_n", core_rst_n, 1);
    check("run_ld_ready", ld_ready, 0);
    check("run_fetch_addr8", i_mem_data, 32'h0020_81B3);

    // ---- RUN-state read/write vectors ----
    vecs = '{
      '{1'b0, 6'd0,  64'h0, 64'h1111,                 6'd0,  32'h0050_0093},
      '{1'b0, 6'd8,  64'h0, 64'h2222,                 6'd4,  32'h00A0_0113},
      '{1'b0, 6'd13, 64'h0, 64'h2222,                 6'd8,  32'h0020_81B3},
      '{1'b1, 6'd16, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,  6'd10, 32'h0020_81B3},
      '{1'b0, 6'd16, 64'h0, 64'hDEAD_BEEF_CAFE_F00D,  6'd1,  32'h0050_0093},
      '{1'b1, 6'd63, 64'h0123_4567_89AB_CDEF, 64'h0,  6'd7,  32'h00A0_0113},
      '{1'b0, 6'd56, 64'h0, 64'h0123_4567_89AB_CDEF,  6'd0,  32'h0050_0093},
      '{1'b0, 6'd21, 64'h0, 64'hDEAD_BEEF_CAFE_F00D,  6'd11, 32'h0020_81B3},
      '{1'b0, 6'd8,  64'h0, 64'h2222,                 6'd4,  32'h00A0_0113}
    };
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      i_mem_addr = vecs[i].i_addr;
      d_mem_addr = vecs[i].d_addr;
      d_mem_we   = vecs[i].we;
      tb_oe      = vecs[i].we;
      tb_wdata   = vecs[i].wdata;
      if (!vecs[i].we) sb_q.push_back(vecs[i].d_exp);
      @(negedge clk);
      check($sformatf("vec%0d_fetch", i), i_mem_data, vecs[i].i_exp);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_bus_released", i), dut.bus_oe, 0);
        check($sformatf("vec%0d_bus_wdata", i), d_mem_data, vecs[i].wdata);
      end else begin
        check($sformatf("vec%0d_read", i), d_mem_data, sb_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    d_mem_we = 1'b0;
    tb_oe    = 1'b0;

    // ---- Loader traffic ignored in RUN ----
    ld_valid   = 1'b1;
    ld_data    = 64'hFFFF;
    ld_last    = 1'b1;
    d_mem_addr = 6'd0;
    i_mem_addr = 6'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("run_ignore_ld_ready%0d", i), ld_ready, 0);
    end
    check("run_ignore_core_rst_n", core_rst_n, 1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    run_read("run_ignore_mem", 6'd0, 32'h0050_0093, 6'd0, 64'h1111);

    // ---- Max-depth phase end, ld_valid toggling every other cycle ----
    do_reset();
    for (int k = 0; k < 16; k++) begin
      ld_word(64'h1000_0000 + 64'(k), 1'b0, 1);
    end
    check("imax_core_rst_n", core_rst_n, 0);
    check("imax_ld_ready", ld_ready, 1);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("dmax_pre_core_rst_n", core_rst_n, 0);
      ld_word(64'h5000 + 64'(k), 1'b0, 1);
    end
    check("dmax_core_rst_n", core_rst_n, 1);
    check("dmax_ld_ready", ld_ready, 0);
    run_read("depth_a", 6'd60, 32'h1000_000F, 6'd56, 64'h5007);
    run_read("depth_b", 6'd0,  32'h1000_0000, 6'd8,  64'h5001);

    // ---- Reset during LOAD_D, then partial reload ----
    do_reset();
    ld_word(64'hABCD_0001, 1'b1, 0);
    ld_word(64'h3333, 1'b0, 0);
    ld_word(64'h4444, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_core_rst_n", core_rst_n, 0);
    check("midrst_ld_ready", ld_ready, 0);
    check("midrst_i_mem_nop", i_mem_data, 32'h0000_0013);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reload_ld_ready", ld_ready, 1);
    check("reload_core_rst_n", core_rst_n, 0);
    ld_word(64'h0000_0093, 1'b1, 0);
    ld_word(64'h7777, 1'b1, 0);
    check("reload_run_core_rst_n", core_rst_n, 1);
    run_read("reload_a", 6'd0,  32'h0000_0093, 6'd0,  64'h7777);
    run_read("reload_b", 6'd4,  32'h1000_0001, 6'd8,  64'h4444);
    run_read("reload_c", 6'd60, 32'h1000_000F, 6'd16, 64'h5002);
    run_read("reload_d", 6'd8,  32'h1000_0002, 6'd56, 64'h5007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
